// File: rtl/miriscv_dmem_responder.sv
// miriscv_dmem_responder
// Slave end of the miriscv LSU data interface (req/gnt/rvalid handshake).
// Accepts one load or store at a time and holds it for a fixed number of
// wait cycles. It then performs a byte-enabled store or a word load on an
// internal word array and returns a single-cycle rvalid pulse.
// Optional build macro: MIRISCV_DMEM_RANDOM_STALL_EN. When it is defined, an
// 8-bit Galois LFSR adds 0..3 pseudo-random extra wait cycles to each access.

module miriscv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    // Width of the word index into the array.
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Wide enough for WAIT_CYCLES (max 15) plus up to 3 random extra cycles.
    localparam int unsigned CNT_W = 5;

    // Byte span of the array. It is kept 33 bits wide so that a full
    // 4 GiB array cannot overflow the comparison.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [CNT_W-1:0]    r_waitCnt;
    logic [CNT_W-1:0]    w_loadCnt;

    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;

    logic [31:0]         r_mem [DEPTH_WORDS];

    logic [31:0]         w_offset;
    logic                w_inRange;
    logic [IDX_W-1:0]    w_index;
    logic                w_unusedOffsetBits;

    logic                w_gnt;
    logic                w_respValid;
    logic                w_respErr;
    logic [31:0]         w_respData;
    logic                w_memWe;

    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic                r_err;

    // Address decode works on the latched request. A plain 32-bit
    // subtraction is used, so an address below BASE_ADDR wraps to a large
    // offset and therefore falls out of range.
    assign w_offset           = r_addr - BASE_ADDR;
    assign w_inRange          = ({1'b0, w_offset} < SPAN);
    assign w_index            = w_offset[IDX_W+1:2];
    assign w_unusedOffsetBits = ^w_offset[1:0];

`ifdef MIRISCV_DMEM_RANDOM_STALL_EN
    logic [7:0] r_lfsr;

    // Free-running Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, reseeded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign w_loadCnt = CNT_W'(WAIT_CYCLES) + {3'b000, r_lfsr[1:0]};
`else
    assign w_loadCnt = CNT_W'(WAIT_CYCLES);
`endif

    // State register. Reset drops any in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A zero wait count skips WAIT and goes straight to RESP.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_nextState = (w_loadCnt == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_waitCnt <= CNT_W'(1)) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: grant, array write strobe and the response to register.
    always_comb begin
        w_gnt       = data_req_i && (r_state == ST_IDLE) && !rst_i;
        w_respValid = (r_state == ST_RESP) && !rst_i;
        w_memWe     = w_respValid && r_we && w_inRange;
        w_respErr   = w_respValid && !w_inRange;
        w_respData  = '0;
        if (w_respValid && !r_we && w_inRange) begin
            w_respData = r_mem[w_index];
        end
    end

    // Capture the request only at the grant edge. Later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_gnt) begin
            r_we    <= data_we_i;
            r_be    <= data_be_i;
            r_addr  <= data_addr_i;
            r_wdata <= data_wdata_i;
        end
    end

    // Wait counter: loaded at grant and decremented once per WAIT cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_waitCnt <= '0;
        end else if (w_gnt) begin
            r_waitCnt <= w_loadCnt;
        end else if ((r_state == ST_WAIT) && (r_waitCnt != '0)) begin
            r_waitCnt <= r_waitCnt - CNT_W'(1);
        end
    end

    // Byte-enabled array write. The array is deliberately not cleared on reset.
    always_ff @(posedge clk_i) begin
        if (w_memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered response. This yields a one-cycle rvalid pulse after RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_respValid;
            r_rdata  <= w_respData;
            r_err    <= w_respErr;
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err;

endmodule

// File: tb/tb_miriscv_dmem_responder.sv
// Directed bench for miriscv_dmem_responder. It uses three instances with
// WAIT_CYCLES of 0, 1 and 3. All instances share clock, reset and request
// fields; each has its own req line.

module tb_miriscv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt [3];
    logic        rvalid [3];
    logic [31:0] rdata [3];
    logic        err [3];

    int          checkCount = 0;
    int          errorCount = 0;

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [6:0]  gntSeq;
    logic [6:0]  rvSeq;
    logic        sawRvalid;

    always #5 clk = ~clk;

    miriscv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dutW0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
    );

    miriscv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dutW1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
    );

    miriscv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dutW3 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iWe, input logic [3:0] iBe,
                                 input logic [31:0] iAddr, input logic [31:0] iWdata);
        we    = iWe;
        be    = iBe;
        addr  = iAddr;
        wdata = iWdata;
    endtask

    // One access on instance d. lat counts rising edges from the grant edge
    // (counted as 1) to the edge after which rvalid is observed high.
    task automatic doAccess(input int d, input logic iWe, input logic [3:0] iBe,
                            input logic [31:0] iAddr, input logic [31:0] iWdata,
                            output int oLat, output logic [31:0] oRd, output logic oEr);
        int guard;
        oLat = -1;
        oRd  = 32'hFFFF_FFFF;
        oEr  = 1'b1;
        @(negedge clk);
        applyStimulus(iWe, iBe, iAddr, iWdata);
        req[d] = 1'b1;
        #1;
        guard = 0;
        while (!gnt[d] && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!gnt[d]) begin
            checkOutput("gnt_timeout", 32'(gnt[d]), 32'd1);
            req[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        applyStimulus(1'b1, 4'hF, 32'h0000_0040, 32'h5A5A_5A5A);
        oLat = 1;
        @(negedge clk);
        while (!rvalid[d] && oLat < 30) begin
            @(posedge clk);
            oLat++;
            @(negedge clk);
        end
        if (!rvalid[d]) begin
            checkOutput("rvalid_timeout", 32'(rvalid[d]), 32'd1);
            oLat = -1;
            return;
        end
        oRd = rdata[d];
        oEr = err[d];
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);

        // Reset held for two cycles; gnt must stay low while reset is high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        req[1] = 1'b1;
        #1;
        checkOutput("gnt_in_reset", 32'(gnt[1]), 32'd0);
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_rvalid", 32'(rvalid[d]), 32'd0);
            checkOutput("rst_err", 32'(err[d]), 32'd0);
            checkOutput("rst_rdata", rdata[d], 32'd0);
            checkOutput("idle_gnt", 32'(gnt[d]), 32'd0);
        end
        sawRvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sawRvalid = sawRvalid | rvalid[1] | err[1] | (|rdata[1]);
        end
        checkOutput("idle_quiet", 32'(sawRvalid), 32'd0);

        // Full-word store and load on the WAIT_CYCLES=1 instance.
        doAccess(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        checkOutput("st_lat", 32'(lat), 32'd3);
        checkOutput("st_err", 32'(er), 32'd0);
        checkOutput("st_rdata", rd, 32'd0);
        @(negedge clk);
        checkOutput("st_pulse", 32'(rvalid[1]), 32'd0);
        doAccess(1, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er);
        checkOutput("ld_lat", 32'(lat), 32'd3);
        checkOutput("ld_err", 32'(er), 32'd0);
        checkOutput("ld_rdata", rd, 32'hDEAD_BEEF);

        // Partial store, then an empty byte-enable store, then an unaligned load.
        doAccess(1, 1'b1, 4'b0101, 32'h10, 32'h1122_3344, lat, rd, er);
        doAccess(1, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er);
        checkOutput("be0101_rdata", rd, 32'hDE22_BE44);
        doAccess(1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, lat, rd, er);
        doAccess(1, 1'b0, 4'h0, 32'h13, 32'h0, lat, rd, er);
        checkOutput("be0000_rdata", rd, 32'hDE22_BE44);

        // Range boundary: the first address past the end faults and must not alias word 0.
        doAccess(1, 1'b1, 4'hF, 32'h0, 32'h0000_0000, lat, rd, er);
        doAccess(1, 1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, er);
        checkOutput("oor_ld_err", 32'(er), 32'd1);
        checkOutput("oor_ld_rdata", rd, 32'd0);
        doAccess(1, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, lat, rd, er);
        checkOutput("oor_st_err", 32'(er), 32'd1);
        doAccess(1, 1'b0, 4'hF, 32'h0, 32'h0, lat, rd, er);
        checkOutput("oor_no_alias", rd, 32'd0);
        doAccess(1, 1'b1, 4'hF, 32'h0FFC, 32'h0BAD_CAFE, lat, rd, er);
        doAccess(1, 1'b0, 4'hF, 32'h0FFC, 32'h0, lat, rd, er);
        checkOutput("last_word_err", 32'(er), 32'd0);
        checkOutput("last_word_rdata", rd, 32'h0BAD_CAFE);

        // Back-to-back loads with req held high on the WAIT_CYCLES=0 instance.
        @(negedge clk);
        applyStimulus(1'b0, 4'hF, 32'h10, 32'h0);
        req[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) req[0] = 1'b0;
            #1;
            gntSeq[6-i] = gnt[0];
            rvSeq[6-i]  = rvalid[0];
            @(negedge clk);
        end
        checkOutput("b2b_gnt_seq", 32'(gntSeq), 32'h54);
        checkOutput("b2b_rvalid_seq", 32'(rvSeq), 32'h15);

        // Longer latency on the WAIT_CYCLES=3 instance.
        doAccess(2, 1'b1, 4'hF, 32'h30, 32'h8765_4321, lat, rd, er);
        checkOutput("w3_st_lat", 32'(lat), 32'd5);
        doAccess(2, 1'b0, 4'hF, 32'h30, 32'h0, lat, rd, er);
        checkOutput("w3_ld_lat", 32'(lat), 32'd5);
        checkOutput("w3_ld_rdata", rd, 32'h8765_4321);

        // Reset during WAIT of a store: no rvalid and no write.
        doAccess(1, 1'b1, 4'hF, 32'h20, 32'h0000_0000, lat, rd, er);
        @(negedge clk);
        applyStimulus(1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
        req[1] = 1'b1;
        #1;
        checkOutput("midrst_gnt", 32'(gnt[1]), 32'd1);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sawRvalid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sawRvalid = sawRvalid | rvalid[1];
        end
        checkOutput("midrst_no_rvalid", 32'(sawRvalid), 32'd0);
        doAccess(1, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, er);
        checkOutput("midrst_no_write", rd, 32'h0000_0000);

        // Sixteen loads; with random stalls the latency stays within 3..6.
        for (int i = 0; i < 16; i++) begin
            doAccess(1, 1'b1, 4'hF, 32'h100 + 32'(4*i), 32'h1357_0000 + 32'(i) * 32'h0001_0111, lat, rd, er);
        end
        for (int i = 0; i < 16; i++) begin
            doAccess(1, 1'b0, 4'hF, 32'h100 + 32'(4*i), 32'h0, lat, rd, er);
            checkOutput("rnd_rdata", rd, 32'h1357_0000 + 32'(i) * 32'h0001_0111);
`ifdef MIRISCV_DMEM_RANDOM_STALL_EN
            checkOutput("rnd_lat_range", 32'((lat >= 3) && (lat <= 6)), 32'd1);
`else
            checkOutput("rnd_lat_exact", 32'(lat), 32'd3);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/miriscv_dmem_responder.md
Name: miriscv_dmem_responder

Overview:
- Synchronous data-memory responder: the slave end of the miriscv LSU data interface (req/gnt/rvalid handshake).
- Accepts one load/store at a time and applies a configurable wait-state latency.
- Performs byte-enabled writes and word reads on an internal word array, then returns a single rvalid pulse.
- Sits between the miriscv core's data port and the top level; testbenches use it to exercise LSU stalls.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 1, fixed cycles spent in WAIT between grant and response (0..15).

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous active-high reset.
- data_req_i  input  1  request valid from LSU.
- data_we_i  input  1  1 = store, 0 = load.
- data_be_i  input  4  byte enables, bit n covers wdata[8n+7:8n].
- data_addr_i  input  32  byte address; bits [1:0] ignored.
- data_wdata_i  input  32  store data.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, one-cycle pulse.
- data_rdata_o  output  32  load data; valid only with rvalid.
- data_err_o  output  1  access fault, valid only with rvalid.

Behaviour:
- Reset (rst_i high at a rising edge):
  - State goes to IDLE; wait counter and latched request are cleared.
  - data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0.
  - Array contents are NOT cleared.
- data_gnt_o is combinational: data_req_i && state==IDLE && !rst_i.
- States:
  - IDLE: on gnt, latch we/be/addr/wdata and load counter = WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: decrement the counter each cycle. Go to RESP on the cycle the counter reaches 0. data_req_i is ignored (gnt=0).
  - RESP: execute the access and register rvalid/rdata/err for the next cycle. Return to IDLE.
- Latency: data_rvalid_o is high exactly WAIT_CYCLES+2 edges after the grant edge, for one cycle.
- Back-to-back requests: the earliest next grant is the cycle in which rvalid is high (state is IDLE). This means rvalid for request N and gnt for request N+1 can coincide.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2.
  - In range if BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; 32-bit subtraction, with wrap treated as out of range.
- Store, in range:
  - Write only the bytes with be set; be=4'b0000 writes nothing.
  - rvalid=1, rdata=0, err=0.
- Load, in range:
  - rdata = full word at index; be is ignored.
  - Read-after-write to the same address returns the new data.
- Out of range (load or store): no array write, rvalid=1, rdata=0, err=1.
- Reset mid-operation: an in-flight request is dropped, no write occurs, and no rvalid is produced.
- Request inputs are sampled only at the grant edge; changes to them during WAIT have no effect.

Optional Feature:
- Macro: MIRISCV_DMEM_RANDOM_STALL_EN.
- Enabled:
  - An 8-bit Galois LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle.
  - At grant, the counter is loaded with WAIT_CYCLES + lfsr[1:0], adding 0..3 extra wait cycles.
  - A total of 0 still goes straight to RESP.
- Disabled: the LFSR is absent and latency is exactly WAIT_CYCLES+2.

Test Plan:
- Reset with rst_i held 2 cycles, then idle → rvalid=0, err=0, rdata=0 throughout; gnt=0 while req=0.
- Store addr=0x10, be=4'hF, wdata=0xDEADBEEF, WAIT_CYCLES=1, then load 0x10 → gnt on the request cycle; store rvalid 3 edges later with err=0; load returns rdata=0xDEADBEEF.
- Store addr=0x10, be=4'b0101, wdata=0x11223344 over 0xDEADBEEF, then load → rdata=0xDE22BE44.
- Load addr=BASE_ADDR+4*DEPTH_WORDS (0x1000 at default) → rvalid=1, err=1, rdata=0; a following load of 0x0FFC returns err=0.
- req held high for 3 consecutive requests with WAIT_CYCLES=0 → gnt every 2 cycles, with rvalid and the next gnt coinciding; WAIT_CYCLES=3 → rvalid 5 edges after each gnt.
- rst_i asserted during WAIT of a store to 0x20 (old value 0x0) → no rvalid; a subsequent load of 0x20 returns 0x00000000.
- With MIRISCV_DMEM_RANDOM_STALL_EN defined: 16 loads → every latency is in [WAIT_CYCLES+2, WAIT_CYCLES+5] and the data is correct.
